// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU divider: default width,
// iteration-counter width and the FSM state encoding.
package alu_pkg;

  localparam int DIV_WIDTH = 32;

  // Counter must hold the values 0..DIV_WIDTH.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_div_seq_if.sv
// Request/response bundle between the execute stage (master) and the
// sequential divider (slave). signed_op only exists when
// ALU_DIV_SIGNED_EN is defined.
//
// Handshake: the master raises start for one cycle while busy is low;
// dividend/divisor are sampled on that edge. start while busy is high is
// dropped. done pulses for one cycle when quotient/remainder/div_by_zero
// are valid; those hold until the next accepted start or rst.
interface alu_div_seq_if #(
  parameter int WIDTH = alu_pkg::DIV_WIDTH
);

  logic             start;
`ifdef ALU_DIV_SIGNED_EN
  logic             signed_op;
`endif
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

`ifdef ALU_DIV_SIGNED_EN
  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif

endinterface

// File: rtl/div_sub_stage.sv
// Single trial-subtract stage of the restoring divider. Subtracts two
// WIDTH+1-bit values; the sign bit of the difference is the borrow that
// tells the caller to restore. Only the low WIDTH bits of the difference
// are returned, since a non-negative trial always fits in WIDTH bits.
module div_sub_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH:0]   i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  logic [WIDTH:0] w_full;

  assign w_full   = i_a - i_b;
  assign o_diff   = w_full[WIDTH-1:0];
  assign o_borrow = w_full[WIDTH];

endmodule

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divider (one quotient bit per clock, WIDTH
// iterations). Zero divisor short-circuits straight to DONE.
// Optional signed division is compiled in with ALU_DIV_SIGNED_EN.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  alu_div_seq_if.slave div_if,
  output div_state_t   o_state
);

  localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_done;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;
  logic [WIDTH-1:0] w_a_lat;
  logic [WIDTH-1:0] w_b_lat;
  logic             w_div_zero;
  logic             w_last;

  assign w_div_zero = (div_if.divisor == '0);
  assign w_last     = (r_cnt == LAST_ITER);

  // One shared subtract stage: shift in the next dividend bit, then try
  // to take the divisor out of the partial remainder.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .i_a      (w_rem_sh),
    .i_b      ({1'b0, r_divisor}),
    .o_diff   (w_trial),
    .o_borrow (w_borrow)
  );
  assign w_rem_nxt = w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};

`ifdef ALU_DIV_SIGNED_EN
  // Signed ops run on magnitudes; signs are re-applied on the last CALC
  // edge. The most negative value maps to itself, which is its correct
  // unsigned magnitude, so MIN / -1 needs no special case.
  logic w_neg_a;
  logic w_neg_b;
  logic r_neg_q;
  logic r_neg_r;
  assign w_neg_a   = div_if.signed_op & div_if.dividend[WIDTH-1];
  assign w_neg_b   = div_if.signed_op & div_if.divisor[WIDTH-1];
  assign w_a_lat   = w_neg_a ? -div_if.dividend : div_if.dividend;
  assign w_b_lat   = w_neg_b ? -div_if.divisor  : div_if.divisor;
  assign w_q_final = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_final = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  // Remember which signs to apply to the results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == IDLE && div_if.start) begin
      r_neg_q <= w_neg_a ^ w_neg_b;
      r_neg_r <= w_neg_a;
    end
  end
`else
  assign w_a_lat   = div_if.dividend;
  assign w_b_lat   = div_if.divisor;
  assign w_q_final = w_quo_nxt;
  assign w_r_final = w_rem_nxt;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (div_if.start) w_state_nxt = w_div_zero ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (div_if.start) begin
            r_quo     <= w_a_lat;
            r_divisor <= w_b_lat;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_dbz     <= w_div_zero;
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= div_if.dividend;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_quotient  <= w_q_final;
            r_remainder <= w_r_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_if.busy        = (r_state != IDLE);
  assign div_if.done        = r_done;
  assign div_if.quotient    = r_quotient;
  assign div_if.remainder   = r_remainder;
  assign div_if.div_by_zero = r_dbz;
  assign o_state            = r_state;

endmodule
